// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: IDLE/FETCH/DECODE/EXEC/MEM/WB/TRAP control FSM.
// Optional memory-wait timeout trap is enabled by defining SEQ_MEM_TIMEOUT_EN.
module core_sequencer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [6:0] opcode,
    input  logic       RegWrite,
    input  logic       MemRead,
    input  logic       MemWrite,
    input  logic       branch,
    input  logic       branch_taken,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       ir_we,
    output logic       pc_we,
    output logic       pc_sel,
    output logic       reg_we,
    output logic       retire,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6,
        S_BAD    = 3'd7
    } state_t;

    state_t     state_q, state_d;
    logic       pc_sel_q, pc_sel_d;
    logic       trap_q, trap_d;
    logic [1:0] cause_q, cause_d;

    logic imem_req_c, dmem_req_c, dmem_we_c, ir_we_c;
    logic pc_we_c, pc_sel_c, reg_we_c, retire_c, done_c;
    logic timeout_hit;

    function automatic logic legal_op(input logic [6:0] op);
        case (op)
            7'b0000011, 7'b0010011, 7'b0010111, 7'b0100011, 7'b0110011,
            7'b0110111, 7'b1100011, 7'b1100111, 7'b1101111: legal_op = 1'b1;
            default: legal_op = 1'b0;
        endcase
    endfunction

`ifdef SEQ_MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;

    // Counter only advances while a request is outstanding; any exit clears it.
    always_comb begin
        wait_cnt_d = '0;
        if ((state_q == S_FETCH && !imem_ready) || (state_q == S_MEM && !dmem_ready))
            wait_cnt_d = wait_cnt_q + CW'(1);
    end

    assign timeout_hit = (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) wait_cnt_q <= '0;
        else     wait_cnt_q <= wait_cnt_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_sel_d   = pc_sel_q;
        trap_d     = trap_q;
        cause_d    = cause_q;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        ir_we_c    = 1'b0;
        pc_we_c    = 1'b0;
        pc_sel_c   = 1'b0;
        reg_we_c   = 1'b0;
        retire_c   = 1'b0;
        done_c     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ready) begin
                    ir_we_c = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 2'd2;
                end
            end
            S_DECODE: begin
                if (legal_op(opcode)) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 2'd1;
                end
            end
            S_EXEC: begin
                pc_sel_d = branch & branch_taken;
                if (MemRead | MemWrite) state_d = S_MEM;
                else if (RegWrite)      state_d = S_WB;
                else                    done_c  = 1'b1;
            end
            S_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = MemWrite;
                if (dmem_ready) begin
                    // A combined read+write is a store and never writes back.
                    if (RegWrite && !(MemRead && MemWrite)) state_d = S_WB;
                    else                                    done_c  = 1'b1;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 2'd2;
                end
            end
            S_WB: begin
                reg_we_c = 1'b1;
                done_c   = 1'b1;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase

        if (done_c) begin
            pc_we_c  = 1'b1;
            pc_sel_c = pc_sel_d;
            retire_c = 1'b1;
            state_d  = run ? S_FETCH : S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_sel_q <= 1'b0;
            trap_q   <= 1'b0;
            cause_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            pc_sel_q <= pc_sel_d;
            trap_q   <= trap_d;
            cause_q  <= cause_d;
        end
    end

    // Strobes are suppressed while reset is asserted so nothing retires in that cycle.
    assign imem_req   = imem_req_c & ~rst;
    assign dmem_req   = dmem_req_c & ~rst;
    assign dmem_we    = dmem_we_c  & ~rst;
    assign ir_we      = ir_we_c    & ~rst;
    assign pc_we      = pc_we_c    & ~rst;
    assign pc_sel     = pc_sel_c   & ~rst;
    assign reg_we     = reg_we_c   & ~rst;
    assign retire     = retire_c   & ~rst;
    assign trap       = trap_q;
    assign trap_cause = cause_q;
    assign state      = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: table of per-cycle vectors plus hand-written multi-cycle sequences.
// Define SEQ_MEM_TIMEOUT_EN for both files to exercise the timeout trap.
module tb_core_sequencer;

    logic       clk = 1'b0;
    logic       rst, run, RegWrite, MemRead, MemWrite, branch, branch_taken;
    logic       imem_ready, dmem_ready;
    logic [6:0] opcode;
    logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, reg_we, retire, trap;
    logic [1:0] trap_cause;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] OP_ALU = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    // exp = {state, imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, reg_we, retire, trap, trap_cause}
    // ctl = {RegWrite, MemRead, MemWrite, branch, branch_taken, imem_ready, dmem_ready}
    typedef struct {
        string       name;
        logic        run;
        logic [6:0]  op;
        logic [6:0]  ctl;
        logic [13:0] exp;
    } vec_t;

    vec_t tbl[$];

    core_sequencer #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .branch(branch), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we),
        .retire(retire), .trap(trap), .trap_cause(trap_cause), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mkv(string n, logic r, logic [6:0] op, logic [6:0] ctl,
                                 logic [2:0] st, logic [8:0] sb, logic [1:0] cause);
        vec_t v;
        v.name = n;
        v.run  = r;
        v.op   = op;
        v.ctl  = ctl;
        v.exp  = {st, sb, cause};
        return v;
    endfunction

    function automatic logic [13:0] observed();
        return {state, imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel,
                reg_we, retire, trap, trap_cause};
    endfunction

    task automatic chk(input string name, input logic [13:0] got, input logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        run = v.run;
        opcode = v.op;
        {RegWrite, MemRead, MemWrite, branch, branch_taken, imem_ready, dmem_ready} = v.ctl;
    endtask

    task automatic step(input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        chk(v.name, observed(), v.exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        run = 1'b0;
        opcode = 7'd0;
        {RegWrite, MemRead, MemWrite, branch, branch_taken, imem_ready, dmem_ready} = 7'd0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int mem_seen, retire_cyc, wb_cyc, we_seen, retires;

        rst = 1'b1;
        run = 1'b0;
        opcode = 7'd0;
        {RegWrite, MemRead, MemWrite, branch, branch_taken, imem_ready, dmem_ready} = 7'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_state", observed(), 14'd0);

        // Back-to-back ALU, taken branch, untaken branch, store, read+write store, then stop.
        tbl.push_back(mkv("alu_idle", 1, OP_ALU, 7'b1000011, 3'd0, 9'b000000000, 2'd0));
        tbl.push_back(mkv("alu_f",    1, OP_ALU, 7'b1000011, 3'd1, 9'b100100000, 2'd0));
        tbl.push_back(mkv("alu_d",    1, OP_ALU, 7'b1000011, 3'd2, 9'b000000000, 2'd0));
        tbl.push_back(mkv("alu_e",    1, OP_ALU, 7'b1000011, 3'd3, 9'b000000000, 2'd0));
        tbl.push_back(mkv("alu_wb",   1, OP_ALU, 7'b1000011, 3'd5, 9'b000010110, 2'd0));
        tbl.push_back(mkv("brt_f",    1, OP_BR,  7'b0001111, 3'd1, 9'b100100000, 2'd0));
        tbl.push_back(mkv("brt_d",    1, OP_BR,  7'b0001111, 3'd2, 9'b000000000, 2'd0));
        tbl.push_back(mkv("brt_e",    1, OP_BR,  7'b0001111, 3'd3, 9'b000011010, 2'd0));
        tbl.push_back(mkv("brn_f",    1, OP_BR,  7'b0001011, 3'd1, 9'b100100000, 2'd0));
        tbl.push_back(mkv("brn_d",    1, OP_BR,  7'b0001011, 3'd2, 9'b000000000, 2'd0));
        tbl.push_back(mkv("brn_e",    1, OP_BR,  7'b0001011, 3'd3, 9'b000010010, 2'd0));
        tbl.push_back(mkv("st_f",     1, OP_ST,  7'b0010011, 3'd1, 9'b100100000, 2'd0));
        tbl.push_back(mkv("st_d",     1, OP_ST,  7'b0010011, 3'd2, 9'b000000000, 2'd0));
        tbl.push_back(mkv("st_e",     1, OP_ST,  7'b0010011, 3'd3, 9'b000000000, 2'd0));
        tbl.push_back(mkv("st_m",     1, OP_ST,  7'b0010011, 3'd4, 9'b011010010, 2'd0));
        tbl.push_back(mkv("rmw_f",    1, OP_ST,  7'b1110011, 3'd1, 9'b100100000, 2'd0));
        tbl.push_back(mkv("rmw_d",    1, OP_ST,  7'b1110011, 3'd2, 9'b000000000, 2'd0));
        tbl.push_back(mkv("rmw_e",    1, OP_ST,  7'b1110011, 3'd3, 9'b000000000, 2'd0));
        tbl.push_back(mkv("rmw_m",    0, OP_ST,  7'b1110011, 3'd4, 9'b011010010, 2'd0));
        tbl.push_back(mkv("stop",     0, OP_ST,  7'b1110011, 3'd0, 9'b000000000, 2'd0));
        tbl.push_back(mkv("stay_idle",0, OP_ALU, 7'b1000011, 3'd0, 9'b000000000, 2'd0));

        do_reset();
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Load with dmem_ready arriving in the fourth MEM cycle; run drops mid-instruction.
        do_reset();
        mem_seen = 0; retire_cyc = -1; wb_cyc = -1; we_seen = 0; retires = 0;
        for (int cyc = 0; cyc < 11; cyc++) begin
            @(negedge clk);
            run = (cyc < 2);
            opcode = OP_LD;
            {RegWrite, MemRead, MemWrite, branch, branch_taken} = 5'b11000;
            imem_ready = 1'b1;
            dmem_ready = (mem_seen == 3);
            #1;
            if (dmem_req) mem_seen++;
            if (dmem_we) we_seen++;
            if (retire) begin
                retires++;
                retire_cyc = cyc;
            end
            if (reg_we) wb_cyc = cyc;
        end
        chk_int("ld_dmem_req_cycles", mem_seen, 4);
        chk_int("ld_dmem_we_cycles", we_seen, 0);
        chk_int("ld_retire_cycle", retire_cyc, 8);
        chk_int("ld_wb_cycle", wb_cyc, 8);
        chk_int("ld_retire_count", retires, 1);
        chk("ld_end_idle", observed(), 14'd0);

        // Illegal opcode traps after DECODE and ignores run until reset.
        do_reset();
        step(mkv("ill_idle", 1, OP_BAD, 7'b0000011, 3'd0, 9'b000000000, 2'd0));
        step(mkv("ill_f",    1, OP_BAD, 7'b0000011, 3'd1, 9'b100100000, 2'd0));
        step(mkv("ill_d",    1, OP_BAD, 7'b0000011, 3'd2, 9'b000000000, 2'd0));
        for (int i = 0; i < 4; i++)
            step(mkv("ill_trap", logic'(i % 2), OP_BAD, 7'b0000011, 3'd6, 9'b000000001, 2'd1));
        do_reset();
        step(mkv("ill_cleared", 0, OP_ALU, 7'b0000011, 3'd0, 9'b000000000, 2'd0));

        // Reset during a MEM cycle that would otherwise complete the store.
        do_reset();
        step(mkv("rm_idle", 1, OP_ST, 7'b0010010, 3'd0, 9'b000000000, 2'd0));
        step(mkv("rm_f",    1, OP_ST, 7'b0010010, 3'd1, 9'b100100000, 2'd0));
        step(mkv("rm_d",    1, OP_ST, 7'b0010010, 3'd2, 9'b000000000, 2'd0));
        step(mkv("rm_e",    1, OP_ST, 7'b0010000, 3'd3, 9'b000000000, 2'd0));
        step(mkv("rm_wait", 1, OP_ST, 7'b0010000, 3'd4, 9'b011000000, 2'd0));
        @(negedge clk);
        dmem_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("rm_rst_cycle", observed(), {3'd4, 9'b000000000, 2'd0});
        @(negedge clk);
        rst = 1'b0;
        run = 1'b0;
        #1;
        chk("rm_after_rst", observed(), 14'd0);

`ifdef SEQ_MEM_TIMEOUT_EN
        // Fetch never completes: trap after four waiting cycles.
        do_reset();
        step(mkv("to_idle", 1, OP_ALU, 7'b1000000, 3'd0, 9'b000000000, 2'd0));
        for (int i = 0; i < 4; i++)
            step(mkv("to_fetch", 1, OP_ALU, 7'b1000000, 3'd1, 9'b100000000, 2'd0));
        step(mkv("to_trap", 1, OP_ALU, 7'b1000000, 3'd6, 9'b000000001, 2'd2));
        step(mkv("to_hold", 0, OP_ALU, 7'b1000000, 3'd6, 9'b000000001, 2'd2));
        do_reset();
        step(mkv("tm_idle", 1, OP_ALU, 7'b1000000, 3'd0, 9'b000000000, 2'd0));
        step(mkv("tm_f1",   1, OP_ALU, 7'b1000000, 3'd1, 9'b100000000, 2'd0));
        step(mkv("tm_f2",   1, OP_ALU, 7'b1000000, 3'd1, 9'b100000000, 2'd0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run = 1'b0;
        #1;
        chk("tm_rst_idle", observed(), 14'd0);
`else
        // Without the timeout, fetch waits indefinitely.
        do_reset();
        step(mkv("nt_idle", 1, OP_ALU, 7'b1000000, 3'd0, 9'b000000000, 2'd0));
        for (int i = 0; i < 12; i++)
            step(mkv("nt_fetch_wait", 1, OP_ALU, 7'b1000000, 3'd1, 9'b100000000, 2'd0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
